// File: rtl/frame_seq_pkg.sv
// Shared encodings for the frame sequencer: FSM states, key indices and
// the grid-select width helper.
package frame_seq_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_X    = 4'd0,
        ST_LOAD_X    = 4'd1,
        ST_WAIT_Y    = 4'd2,
        ST_LOAD_Y    = 4'd3,
        ST_WAIT_A    = 4'd4,
        ST_LOAD_A    = 4'd5,
        ST_START     = 4'd6,
        ST_WAIT      = 4'd7,
        ST_FRAME_END = 4'd8
    } state_t;

    localparam int unsigned KEY_X    = 0;
    localparam int unsigned KEY_Y    = 1;
    localparam int unsigned KEY_A    = 2;
    localparam int unsigned NUM_KEYS = 3;

    // Width of the stage index; never below one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_sequencer_key_edge_sync.sv
// Two-flop synchroniser for one active-low button plus a single-cycle
// press pulse on the synchronised 1->0 transition.
module key_edge_sync (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic press
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= key_n;
            sync <= meta;
            prev <= sync;
        end
    end

    assign press = prev & ~sync;

endmodule

// File: rtl/frame_sequencer.sv
// Pose capture and render-stage sequencer with per-stage start/done handshake.
// Optional stage watchdog enabled by defining FRAME_SEQ_TIMEOUT_EN.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned X_W        = 14,
    parameter int unsigned Y_W        = 13,
    parameter int unsigned ANGLE_W    = 8
`ifdef FRAME_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_W  = 20
`endif
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic [DATA_W-1:0]                data,
    input  logic [2:0]                       key_n,
    input  logic                             continuous,
    input  logic                             abort,
    input  logic [NUM_STAGES-1:0]            stage_done,
    output logic [NUM_STAGES-1:0]            stage_start,
    output logic [sel_w(NUM_STAGES)-1:0]     grid_access,
    output logic [X_W-1:0]                   pos_x,
    output logic [Y_W-1:0]                   pos_y,
    output logic [ANGLE_W-1:0]               angle,
    output logic                             busy,
    output logic                             frame_done,
    output logic [7:0]                       frame_count,
    output logic                             timeout_err
);

    localparam int unsigned SEL_W = sel_w(NUM_STAGES);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_STAGES - 1);

    logic [NUM_KEYS-1:0] press;
    state_t              state;
    logic [SEL_W-1:0]    idx;
    logic                wd_fire;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : gen_key
        key_edge_sync u_sync (
            .clock  (clock),
            .resetn (resetn),
            .key_n  (key_n[k]),
            .press  (press[k])
        );
    end

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] wd_cnt;

    // Fires on the WAIT cycle that would take the counter to all-ones; a done wins.
    assign wd_fire = (state == ST_WAIT) && (wd_cnt == WD_LAST) && !stage_done[idx];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_START) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_WAIT_X;
            idx         <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            angle       <= '0;
            stage_start <= '0;
            grid_access <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            stage_start <= '0;
            frame_done  <= 1'b0;
            // Outputs are set on the transition into each state so they are registered.
            if ((abort && (state != ST_WAIT_X)) || wd_fire) begin
                state       <= ST_WAIT_X;
                idx         <= '0;
                grid_access <= '0;
                busy        <= 1'b0;
            end else begin
                unique case (state)
                    ST_WAIT_X: if (press[KEY_X]) state <= ST_LOAD_X;
                    ST_LOAD_X: begin
                        pos_x <= data[X_W-1:0];
                        state <= ST_WAIT_Y;
                    end
                    ST_WAIT_Y: if (press[KEY_Y]) state <= ST_LOAD_Y;
                    ST_LOAD_Y: begin
                        pos_y <= data[Y_W-1:0];
                        state <= ST_WAIT_A;
                    end
                    ST_WAIT_A: if (press[KEY_A]) state <= ST_LOAD_A;
                    ST_LOAD_A: begin
                        angle       <= data[ANGLE_W-1:0];
                        state       <= ST_START;
                        idx         <= '0;
                        grid_access <= '0;
                        stage_start <= NUM_STAGES'(1);
                        busy        <= 1'b1;
                    end
                    ST_START: state <= ST_WAIT;
                    ST_WAIT: begin
                        if (stage_done[idx]) begin
                            if (idx == LAST_IDX) begin
                                state       <= ST_FRAME_END;
                                frame_done  <= 1'b1;
                                grid_access <= '0;
                            end else begin
                                state       <= ST_START;
                                idx         <= idx + 1'b1;
                                grid_access <= idx + 1'b1;
                                stage_start <= NUM_STAGES'(1) << (idx + 1'b1);
                            end
                        end
                    end
                    ST_FRAME_END: begin
                        frame_count <= frame_count + 1'b1;
                        idx         <= '0;
                        grid_access <= '0;
                        if (continuous) begin
                            state       <= ST_START;
                            stage_start <= NUM_STAGES'(1);
                        end else begin
                            state <= ST_WAIT_X;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= ST_WAIT_X;
                        idx         <= '0;
                        grid_access <= '0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
